wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 151 +++++++++++++++
 tb/tb_wb_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// In-order write-back stage: a small retirement queue that collects ALU results and load
// data, formats loads, and retires strictly in program order onto the regfile write port.
module wb_stage #(
  parameter int DEPTH         = 4,
  parameter int XLEN          = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ex_valid_i,
  output logic                            ex_ready_o,
  input  logic                            ex_rd_en_i,
  input  logic [REG_IDX_WIDTH-1:0]        ex_rd_idx_i,
  input  logic [XLEN-1:0]                 ex_rd_wdata_i,
  input  logic                            ex_is_load_i,
  input  logic [1:0]                      ex_load_size_i,
  input  logic                            ex_load_unsigned_i,
  input  logic [1:0]                      ex_addr_lo_i,
  input  logic                            mem_rvalid_i,
  input  logic [XLEN-1:0]                 mem_rdata_i,
  output logic                            rd_en_o,
  output logic [REG_IDX_WIDTH-1:0]        rd_idx_o,
  output logic [XLEN-1:0]                 rd_wdata_o,
  output logic [(1<<REG_IDX_WIDTH)-1:0]   pend_mask_o,
  output logic                            err_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0]         q_valid;
  logic [DEPTH-1:0]         q_rd_en;
  logic [REG_IDX_WIDTH-1:0] q_rd_idx  [DEPTH];
  logic [XLEN-1:0]          q_data    [DEPTH];
  logic [DEPTH-1:0]         q_is_load;
  logic [1:0]               q_size    [DEPTH];
  logic [DEPTH-1:0]         q_unsigned;
  logic [1:0]               q_addr_lo [DEPTH];
  logic [DEPTH-1:0]         q_data_valid;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          err;

  logic          push;
  logic          retire;
  logic          cap_hit;
  logic [PW-1:0] cap_idx;
  logic [PW-1:0] scan_idx;

  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] w, input logic [1:0] size,
                                               input logic uns, input logic [1:0] alo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*alo +: 8];
    h = alo[1] ? w[16 +: 16] : w[0 +: 16];
    case (size)
      2'b00:   fmt_load = {{(XLEN-8){b[7] & ~uns}}, b};
      2'b01:   fmt_load = {{(XLEN-16){h[15] & ~uns}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Valid/ready: an entry is taken on a clock edge where ex_valid_i and ex_ready_o are both
  // high; ex_ready_o depends only on registered occupancy, never on this cycle's retire.
  assign ex_ready_o = (count != (PW+1)'(DEPTH));
  assign push       = ex_valid_i & ex_ready_o;
  assign retire     = q_valid[head] & q_data_valid[head];

  // Oldest load still waiting for data, scanned from head; this cycle's push is not seen.
  always_comb begin
    cap_hit  = 1'b0;
    cap_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if (!cap_hit && q_valid[scan_idx] && q_is_load[scan_idx] && !q_data_valid[scan_idx]) begin
        cap_hit = 1'b1;
        cap_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      err          <= 1'b0;
      q_valid      <= '0;
      q_rd_en      <= '0;
      q_is_load    <= '0;
      q_unsigned   <= '0;
      q_data_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd_idx[i]  <= '0;
        q_data[i]    <= '0;
        q_size[i]    <= '0;
        q_addr_lo[i] <= '0;
      end
    end else begin
      if (retire) begin
        q_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (mem_rvalid_i) begin
        if (cap_hit) begin
          q_data[cap_idx]       <= fmt_load(mem_rdata_i, q_size[cap_idx], q_unsigned[cap_idx],
                                            q_addr_lo[cap_idx]);
          q_data_valid[cap_idx] <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
      if (push) begin
        q_valid[tail]      <= 1'b1;
        q_rd_en[tail]      <= ex_rd_en_i;
        q_rd_idx[tail]     <= ex_rd_idx_i;
        q_data[tail]       <= ex_rd_wdata_i;
        q_is_load[tail]    <= ex_is_load_i;
        q_size[tail]       <= ex_load_size_i;
        q_unsigned[tail]   <= ex_load_unsigned_i;
        q_addr_lo[tail]    <= ex_addr_lo_i;
        q_data_valid[tail] <= ~ex_is_load_i;
        tail               <= tail + 1'b1;
      end
      case ({push, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rd_en_o    = retire & q_rd_en[head] & (q_rd_idx[head] != '0);
    rd_idx_o   = rd_en_o ? q_rd_idx[head] : '0;
    rd_wdata_o = rd_en_o ? q_data[head] : '0;
  end

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && q_rd_en[i]) pend_mask_o[q_rd_idx[i]] = 1'b1;
    end
    pend_mask_o[0] = 1'b0;
  end

  assign err_o = err;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: an in-order queue model predicts every output each cycle,
// and hand-computed literals pin the model on the key scenarios.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic        ex_rd_en_i = 1'b0;
  logic [4:0]  ex_rd_idx_i = '0;
  logic [31:0] ex_rd_wdata_i = '0;
  logic        ex_is_load_i = 1'b0;
  logic [1:0]  ex_load_size_i = '0;
  logic        ex_load_unsigned_i = 1'b0;
  logic [1:0]  ex_addr_lo_i = '0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        rd_en_o;
  logic [4:0]  rd_idx_o;
  logic [31:0] rd_wdata_o;
  logic [31:0] pend_mask_o;
  logic        err_o;

  wb_stage #(.DEPTH(4), .XLEN(32), .REG_IDX_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_rd_en_i(ex_rd_en_i), .ex_rd_idx_i(ex_rd_idx_i), .ex_rd_wdata_i(ex_rd_wdata_i),
    .ex_is_load_i(ex_is_load_i), .ex_load_size_i(ex_load_size_i),
    .ex_load_unsigned_i(ex_load_unsigned_i), .ex_addr_lo_i(ex_addr_lo_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rd_en_o(rd_en_o), .rd_idx_o(rd_idx_o), .rd_wdata_o(rd_wdata_o),
    .pend_mask_o(pend_mask_o), .err_o(err_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  typedef struct {
    bit          en;
    logic [4:0]  idx;
    logic [31:0] data;
    bit          ld;
    logic [1:0]  size;
    bit          uns;
    logic [1:0]  alo;
    bit          have;
  } ent_t;

  ent_t        exp_q[$];
  bit          m_err = 1'b0;
  bit          chk_on = 1'b0;
  int          n_total = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_fmt(input logic [31:0] w, input logic [1:0] size,
                                            input bit uns, input logic [1:0] alo);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * alo)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (alo[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic model_step();
    bit   ret;
    bit   rdy;
    bit   found;
    ent_t e;
    ret   = (exp_q.size() > 0) && exp_q[0].have;
    rdy   = (exp_q.size() < 4);
    found = 1'b0;
    if (mem_rvalid_i) begin
      foreach (exp_q[i]) begin
        if (!found && exp_q[i].ld && !exp_q[i].have) begin
          exp_q[i].data = model_fmt(mem_rdata_i, exp_q[i].size, exp_q[i].uns, exp_q[i].alo);
          exp_q[i].have = 1'b1;
          found = 1'b1;
        end
      end
      if (!found) m_err = 1'b1;
    end
    if (ret) void'(exp_q.pop_front());
    if (ex_valid_i && rdy) begin
      e.en = ex_rd_en_i; e.idx = ex_rd_idx_i; e.data = ex_rd_wdata_i; e.ld = ex_is_load_i;
      e.size = ex_load_size_i; e.uns = ex_load_unsigned_i; e.alo = ex_addr_lo_i;
      e.have = !ex_is_load_i;
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_err = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      bit          e_ret;
      bit          e_en;
      logic [31:0] e_mask;
      e_ret  = (exp_q.size() > 0) && exp_q[0].have;
      e_en   = e_ret && exp_q[0].en && (exp_q[0].idx != 5'd0);
      e_mask = '0;
      foreach (exp_q[i]) if (exp_q[i].en) e_mask[exp_q[i].idx] = 1'b1;
      e_mask[0] = 1'b0;
      check("ready",  {31'd0, ex_ready_o}, {31'd0, exp_q.size() != 4});
      check("rd_en",  {31'd0, rd_en_o}, {31'd0, e_en});
      check("rd_idx", {27'd0, rd_idx_o}, e_en ? {27'd0, exp_q[0].idx} : 32'd0);
      check("rd_wdata", rd_wdata_o, e_en ? exp_q[0].data : 32'd0);
      check("pend_mask", pend_mask_o, e_mask);
      check("err", {31'd0, err_o}, {31'd0, m_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit en, input logic [4:0] idx, input logic [31:0] data,
                      input bit ld, input logic [1:0] size, input bit uns, input logic [1:0] alo);
    ex_valid_i = 1'b1; ex_rd_en_i = en; ex_rd_idx_i = idx; ex_rd_wdata_i = data;
    ex_is_load_i = ld; ex_load_size_i = size; ex_load_unsigned_i = uns; ex_addr_lo_i = alo;
    tick();
    ex_valid_i = 1'b0;
  endtask

  task automatic alu(input logic [4:0] idx, input logic [31:0] data);
    push(1'b1, idx, data, 1'b0, 2'd2, 1'b0, 2'd0);
  endtask

  task automatic load(input logic [4:0] idx, input logic [1:0] size, input bit uns,
                      input logic [1:0] alo);
    push(1'b1, idx, 32'hBAAD_F00D, 1'b1, size, uns, alo);
  endtask

  task automatic resp(input logic [31:0] w);
    mem_rvalid_i = 1'b1; mem_rdata_i = w;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    check("reset_ready", {31'd0, ex_ready_o}, 32'd1);
    check("reset_rd_en", {31'd0, rd_en_o}, 32'd0);
    check("reset_mask", pend_mask_o, 32'd0);
    check("reset_err", {31'd0, err_o}, 32'd0);

    // ALU write x5, visible the cycle after the push and only then
    alu(5'd5, 32'h1234_5678);
    check("alu_en", {31'd0, rd_en_o}, 32'd1);
    check("alu_idx", {27'd0, rd_idx_o}, 32'd5);
    check("alu_data", rd_wdata_o, 32'h1234_5678);
    check("alu_mask", pend_mask_o, 32'h0000_0020);
    tick();
    check("alu_mask_clear", pend_mask_o, 32'd0);

    // Load formatting
    load(5'd7, 2'd0, 1'b0, 2'd3);
    check("ld_pending_mask", pend_mask_o, 32'h0000_0080);
    check("ld_no_write", {31'd0, rd_en_o}, 32'd0);
    resp(32'h80FF_FF00);
    check("lb_signed", rd_wdata_o, 32'hFFFF_FF80);
    tick();
    load(5'd7, 2'd0, 1'b1, 2'd3);
    resp(32'h80FF_FF00);
    check("lbu", rd_wdata_o, 32'h0000_0080);
    tick();
    load(5'd8, 2'd1, 1'b0, 2'd2);
    resp(32'h80FF_FF00);
    check("lh_signed", rd_wdata_o, 32'hFFFF_80FF);
    tick();

    // Load blocks younger ALU entries; WAW on x3 commits in order
    load(5'd3, 2'd2, 1'b0, 2'd0);
    alu(5'd4, 32'h0000_0044);
    alu(5'd3, 32'h0000_0033);
    for (int i = 0; i < 5; i++) begin
      check("blocked_no_write", {31'd0, rd_en_o}, 32'd0);
      tick();
    end
    check("blocked_mask", pend_mask_o, 32'h0000_0018);
    resp(32'hCAFE_BABE);
    check("order0_idx", {27'd0, rd_idx_o}, 32'd3);
    check("order0_data", rd_wdata_o, 32'hCAFE_BABE);
    tick();
    check("order1_idx", {27'd0, rd_idx_o}, 32'd4);
    check("order1_data", rd_wdata_o, 32'h0000_0044);
    check("order1_mask", pend_mask_o, 32'h0000_0018);
    tick();
    check("order2_idx", {27'd0, rd_idx_o}, 32'd3);
    check("order2_data", rd_wdata_o, 32'h0000_0033);
    check("order2_mask", pend_mask_o, 32'h0000_0008);
    tick();
    check("order_mask_clear", pend_mask_o, 32'd0);

    // Full queue: back-pressure and recovery
    for (int i = 1; i <= 4; i++) load(5'(i), 2'd2, 1'b0, 2'd0);
    check("full_ready", {31'd0, ex_ready_o}, 32'd0);
    load(5'd9, 2'd2, 1'b0, 2'd0);
    check("full_no_push_mask", pend_mask_o, 32'h0000_001E);
    resp(32'h0000_0011);
    check("full_retire_idx", {27'd0, rd_idx_o}, 32'd1);
    check("full_still_full", {31'd0, ex_ready_o}, 32'd0);
    tick();
    check("full_ready_back", {31'd0, ex_ready_o}, 32'd1);
    resp(32'h0000_0022);
    resp(32'h0000_0033);
    resp(32'h0000_0044);
    repeat (2) tick();

    // Back-to-back pushes with simultaneous retire, wrapping the pointers several times
    for (int i = 0; i < 12; i++) begin
      alu(5'((i % 7) + 1), 32'h1000_0000 + 32'(i));
      check("wrap_idx", {27'd0, rd_idx_o}, 32'((i % 7) + 1));
      check("wrap_data", rd_wdata_o, 32'h1000_0000 + 32'(i));
    end
    tick();

    // x0 and rd_en=0 entries retire silently
    alu(5'd0, 32'hDEAD_BEEF);
    check("x0_no_write", {31'd0, rd_en_o}, 32'd0);
    check("x0_mask", pend_mask_o, 32'd0);
    check("x0_data", rd_wdata_o, 32'd0);
    push(1'b0, 5'd6, 32'h0000_0066, 1'b0, 2'd2, 1'b0, 2'd0);
    check("noen_mask", pend_mask_o, 32'd0);
    check("noen_no_write", {31'd0, rd_en_o}, 32'd0);
    tick();

    // Stray response sets sticky error; reset mid-queue clears everything
    resp(32'h0000_0001);
    check("err_set", {31'd0, err_o}, 32'd1);
    repeat (2) tick();
    check("err_sticky", {31'd0, err_o}, 32'd1);
    load(5'd10, 2'd2, 1'b0, 2'd0);
    alu(5'd11, 32'h0000_00BB);
    rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, ex_ready_o}, 32'd1);
    check("rst_mask", pend_mask_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en_o}, 32'd0);
    tick();
    rst = 1'b0;
    resp(32'h0000_00AA);
    check("late_resp_err", {31'd0, err_o}, 32'd1);
    alu(5'd12, 32'h0000_0C0C);
    check("post_rst_write", rd_wdata_o, 32'h0000_0C0C);
    repeat (2) tick();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
